// File: rtl/mem_wb_skid_stage_if.sv
// MEM -> WB handshake bundle for the skid-buffered write-back register.
// master = MEM side / observer, slave = the stage itself.
interface mem_wb_skid_stage_if #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [RD_W-1:0]   in_rdest;
    logic              in_w_reg;
    logic              in_stop;
    logic [DATA_W-1:0] in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rdest;
    logic              out_w_reg;
    logic              out_stop;
    logic [DATA_W-1:0] out_pc;
    logic              halted;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output in_valid, in_result, in_rdest, in_w_reg, in_stop, in_pc,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rdest, out_w_reg,
        input  out_stop, out_pc, halted, retire_count
    );

    modport slave (
        input  in_valid, in_result, in_rdest, in_w_reg, in_stop, in_pc,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rdest, out_w_reg,
        output out_stop, out_pc, halted, retire_count
    );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake and one-entry skid.
// Updates on the falling clock edge like the other pipeline registers.
module mem_wb_skid_stage #(
    parameter int DATA_W = 16,
    parameter int RD_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    mem_wb_skid_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state;

    logic [DATA_W-1:0] main_result;
    logic [RD_W-1:0]   main_rdest;
    logic              main_w_reg;
    logic              main_stop;
    logic [DATA_W-1:0] main_pc;

    logic [DATA_W-1:0] skid_result;
    logic [RD_W-1:0]   skid_rdest;
    logic              skid_w_reg;
    logic              skid_stop;
    logic [DATA_W-1:0] skid_pc;

    logic              halted;
    logic [CNT_W-1:0]  count;

    logic              valid;
    logic              ready;
    logic              accept;
    logic              retire;

    // Handshake decode; ready depends on registered state only.
    always_comb begin
        valid  = (state != EMPTY);
        ready  = (state != SKID) && !halted;
        accept = bus.in_valid && ready;
        retire = valid && bus.out_ready;
    end

    assign bus.in_ready     = ready;
    assign bus.out_valid    = valid;
    assign bus.out_result   = main_result;
    assign bus.out_pc       = main_pc;
    assign bus.out_rdest    = valid ? main_rdest : '0;
    assign bus.out_w_reg    = valid && main_w_reg;
    assign bus.out_stop     = valid && main_stop;
    assign bus.halted       = halted;
    assign bus.retire_count = count;

    // Entry state machine, halt flag and saturating retire counter.
    always_ff @(negedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            main_result <= '0;
            main_rdest  <= '0;
            main_w_reg  <= 1'b0;
            main_stop   <= 1'b0;
            main_pc     <= '0;
            skid_result <= '0;
            skid_rdest  <= '0;
            skid_w_reg  <= 1'b0;
            skid_stop   <= 1'b0;
            skid_pc     <= '0;
            halted      <= 1'b0;
            count       <= '0;
        end else begin
            if (retire) begin
                if (count != {CNT_W{1'b1}}) begin
                    count <= count + CNT_W'(1);
                end
                if (main_stop) begin
                    halted <= 1'b1;
                end
            end
            if (flush) begin
                state <= EMPTY;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_result <= bus.in_result;
                            main_rdest  <= bus.in_rdest;
                            main_w_reg  <= bus.in_w_reg;
                            main_stop   <= bus.in_stop;
                            main_pc     <= bus.in_pc;
                            state       <= FULL;
                        end
                    end
                    FULL: begin
                        if (retire && accept) begin
                            main_result <= bus.in_result;
                            main_rdest  <= bus.in_rdest;
                            main_w_reg  <= bus.in_w_reg;
                            main_stop   <= bus.in_stop;
                            main_pc     <= bus.in_pc;
                        end else if (retire) begin
                            state <= EMPTY;
                        end else if (accept) begin
                            skid_result <= bus.in_result;
                            skid_rdest  <= bus.in_rdest;
                            skid_w_reg  <= bus.in_w_reg;
                            skid_stop   <= bus.in_stop;
                            skid_pc     <= bus.in_pc;
                            state       <= SKID;
                        end
                    end
                    SKID: begin
                        if (retire) begin
                            main_result <= skid_result;
                            main_rdest  <= skid_rdest;
                            main_w_reg  <= skid_w_reg;
                            main_stop   <= skid_stop;
                            main_pc     <= skid_pc;
                            state       <= FULL;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule
